// File: rtl/sfx_pkg.sv
// Shared types, constants and the saturating mixer helper for the
// hit/miss sound-effect sequencer.
package sfx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } sfx_state_t;

   // Event type stored in the queue.
   localparam logic EVT_HIT  = 1'b0;
   localparam logic EVT_MISS = 1'b1;

   localparam int SAMPLE_W = 32;
   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 32'sh8000_0000;

   // Signed add with one guard bit, clamped to the 32-bit sample range.
   function automatic logic signed [SAMPLE_W-1:0] sat32(
      input logic signed [SAMPLE_W-1:0] a,
      input logic signed [SAMPLE_W-1:0] b
   );
      logic signed [SAMPLE_W:0] sum;
      sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
         return sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
      return sum[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/sfx_event_fifo.sv
// Two-entry queue of 1-bit effect types. A miss and a hit arriving on the
// same edge are appended miss first; anything that does not fit is dropped
// and reported with a one-cycle pulse on the following cycle.
module sfx_event_fifo
   import sfx_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic push_hit,
   input  logic push_miss,
   input  logic pop,
   output logic empty,
   output logic head,
   output logic dropped
);

   logic [1:0] slot_q, slot_d;     // slot_q[0] is the head
   logic [1:0] count_q, count_d;
   logic       drop_d, dropped_q;

   // Next queue contents: retire the head first, then append miss, then hit.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and a latch is never inferred.
      slot_d  = slot_q;
      count_d = count_q;
      drop_d  = 1'b0;
      // NOTE: blocking assignments are used on purpose here: the hit append
      // must see the slot and count already updated by the pop and the miss.
      if (pop && (count_q != 2'd0)) begin
         slot_d  = {1'b0, slot_q[1]};
         count_d = count_q - 2'd1;
      end
      if (push_miss) begin
         if (count_d != 2'd2) begin
            slot_d[count_d[0]] = EVT_MISS;
            count_d            = count_d + 2'd1;
         end else begin
            drop_d = 1'b1;
         end
      end
      if (push_hit) begin
         if (count_d != 2'd2) begin
            slot_d[count_d[0]] = EVT_HIT;
            count_d            = count_d + 2'd1;
         end else begin
            drop_d = 1'b1;
         end
      end
   end

   // Queue state and registered drop pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the two storage slots are reset along with the count; it is
         // only two flops and keeps the head value defined out of reset.
         slot_q    <= '0;
         count_q   <= '0;
         dropped_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         count_q   <= count_d;
         dropped_q <= drop_d;
      end
   end

   assign empty   = (count_q == 2'd0);
   assign head    = slot_q[0];
   assign dropped = dropped_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Hit/miss sound-effect sequencer: queues event pulses, plays each as a
// fixed-length square tone, mixes it into the audio sample stream and owns
// the audio FIFO read/write strobes.
// Build option: define SFX_MIC_PASSTHRU_EN to mix the mic samples under the
// tone; without it the output is the tone alone and the input FIFO is drained.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int HIT_HALF_PERIOD  = 6000,
   parameter int MISS_HALF_PERIOD = 12000,
   parameter int HIT_TOGGLES      = 800,
   parameter int MISS_TOGGLES     = 400,
   parameter int GAP_CYCLES       = 250000,
   parameter int AMPLITUDE        = 10000000
) (
   input  logic                       iClock,
   input  logic                       iResetn,
   input  logic                       iHit,
   input  logic                       iMiss,
   input  logic                       iAudioInAvailable,
   input  logic                       iAudioOutAllowed,
   input  logic signed [SAMPLE_W-1:0] iLeftIn,
   input  logic signed [SAMPLE_W-1:0] iRightIn,
   output logic                       oReadAudioIn,
   output logic                       oWriteAudioOut,
   output logic signed [SAMPLE_W-1:0] oLeftOut,
   output logic signed [SAMPLE_W-1:0] oRightOut,
   output logic                       oBusy,
   output logic                       oDropped
);

   sfx_state_t  state_q;
   logic        phase_q;
   logic        cur_evt_q;
   logic [31:0] cyc_cnt_q;
   logic [31:0] tog_cnt_q;

   logic        fifo_empty;
   logic        fifo_head;
   logic        pop;

   logic [31:0] half_last;
   logic [31:0] tog_limit;
   logic signed [SAMPLE_W-1:0] tone;
   logic signed [SAMPLE_W-1:0] mic_left;
   logic signed [SAMPLE_W-1:0] mic_right;

   assign pop = (state_q == IDLE) && !fifo_empty;

   sfx_event_fifo u_event_fifo (
      .clk       (iClock),
      .rst_n     (iResetn),
      .push_hit  (iHit),
      .push_miss (iMiss),
      .pop       (pop),
      .empty     (fifo_empty),
      .head      (fifo_head),
      .dropped   (oDropped)
   );

   // Timing limits of the effect currently playing.
   always_comb begin
      if (cur_evt_q == EVT_MISS) begin
         half_last = 32'(MISS_HALF_PERIOD - 1);
         tog_limit = 32'(MISS_TOGGLES);
      end else begin
         half_last = 32'(HIT_HALF_PERIOD - 1);
         tog_limit = 32'(HIT_TOGGLES);
      end
   end

   // Effect FSM: pop from IDLE, play the square tone, then rest in GAP.
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         state_q   <= IDLE;
         phase_q   <= 1'b1;
         cur_evt_q <= EVT_HIT;
         cyc_cnt_q <= '0;
         tog_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q   <= PLAY;
                  cur_evt_q <= fifo_head;
                  phase_q   <= 1'b1;
                  cyc_cnt_q <= '0;
                  tog_cnt_q <= '0;
               end
            end
            PLAY: begin
               if (cyc_cnt_q == half_last) begin
                  cyc_cnt_q <= '0;
                  phase_q   <= ~phase_q;
                  tog_cnt_q <= tog_cnt_q + 32'd1;
                  if (tog_cnt_q + 32'd1 == tog_limit)
                     state_q <= fifo_empty ? IDLE : GAP;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + 32'd1;
               end
            end
            GAP: begin
               if (cyc_cnt_q == 32'(GAP_CYCLES - 1)) begin
                  cyc_cnt_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + 32'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Square-wave tone term, silent outside PLAY.
   always_comb begin
      tone = '0;
      if (state_q == PLAY)
         tone = phase_q ? AMPLITUDE : -AMPLITUDE;
   end

`ifdef SFX_MIC_PASSTHRU_EN
   assign mic_left       = iLeftIn;
   assign mic_right      = iRightIn;
   assign oReadAudioIn   = iAudioInAvailable & iAudioOutAllowed;
   assign oWriteAudioOut = iAudioInAvailable & iAudioOutAllowed;
`else
   // Mic samples are read and thrown away; only the tone reaches the output.
   logic unused_mic;
   assign unused_mic     = ^{iLeftIn, iRightIn};
   assign mic_left       = '0;
   assign mic_right      = '0;
   assign oReadAudioIn   = iAudioInAvailable;
   assign oWriteAudioOut = iAudioOutAllowed;
`endif

   assign oLeftOut  = sat32(mic_left, tone);
   assign oRightOut = sat32(mic_right, tone);
   assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with short tone/gap parameters.
// Expectations follow the SFX_MIC_PASSTHRU_EN setting of the build.
module tb_sfx_sequencer;

`ifdef SFX_MIC_PASSTHRU_EN
   localparam bit PASSTHRU = 1'b1;
`else
   localparam bit PASSTHRU = 1'b0;
`endif

   localparam logic [31:0] POS = 32'd100;
   localparam logic [31:0] NEG = 32'hFFFF_FF9C;   // -100
   localparam logic [31:0] ONE = 32'd1;
   localparam logic [31:0] ZERO = 32'd0;

   logic        iClock = 1'b0;
   logic        iResetn = 1'b0;
   logic        iHit = 1'b0;
   logic        iMiss = 1'b0;
   logic        iAudioInAvailable = 1'b0;
   logic        iAudioOutAllowed = 1'b0;
   logic [31:0] iLeftIn = '0;
   logic [31:0] iRightIn = '0;
   logic        oReadAudioIn;
   logic        oWriteAudioOut;
   logic [31:0] oLeftOut;
   logic [31:0] oRightOut;
   logic        oBusy;
   logic        oDropped;

   int n_tests = 0;
   int n_fail  = 0;

   sfx_sequencer #(
      .HIT_HALF_PERIOD  (4),
      .MISS_HALF_PERIOD (8),
      .HIT_TOGGLES      (4),
      .MISS_TOGGLES     (2),
      .GAP_CYCLES       (3),
      .AMPLITUDE        (100)
   ) dut (
      .iClock            (iClock),
      .iResetn           (iResetn),
      .iHit              (iHit),
      .iMiss             (iMiss),
      .iAudioInAvailable (iAudioInAvailable),
      .iAudioOutAllowed  (iAudioOutAllowed),
      .iLeftIn           (iLeftIn),
      .iRightIn          (iRightIn),
      .oReadAudioIn      (oReadAudioIn),
      .oWriteAudioOut    (oWriteAudioOut),
      .oLeftOut          (oLeftOut),
      .oRightOut         (oRightOut),
      .oBusy             (oBusy),
      .oDropped          (oDropped)
   );

   always #5 iClock = ~iClock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   initial begin
      // Reset state, with a nonzero mic sample present.
      iLeftIn = 32'h0000_1234;
      #1;
      check("rst_busy", {31'd0, oBusy}, ZERO);
      check("rst_dropped", {31'd0, oDropped}, ZERO);
      check("rst_left", oLeftOut, PASSTHRU ? 32'h0000_1234 : ZERO);
      check("rst_right", oRightOut, ZERO);
      repeat (2) @(posedge iClock);
      #1;
      iResetn = 1'b1;
      iLeftIn = '0;
      tick();
      tick();
      check("idle_busy", {31'd0, oBusy}, ZERO);

      // Test 1: single hit, tone starts one edge after the pulse is queued.
      iHit = 1'b1;
      tick();
      iHit = 1'b0;
      check("t1_queued_busy", {31'd0, oBusy}, ZERO);
      check("t1_queued_left", oLeftOut, ZERO);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t1_tone_left", oLeftOut, ((i / 4) % 2 == 0) ? POS : NEG);
         check("t1_tone_right", oRightOut, ((i / 4) % 2 == 0) ? POS : NEG);
         check("t1_busy", {31'd0, oBusy}, ONE);
      end
      tick();
      check("t1_end_left", oLeftOut, ZERO);
      repeat (6) tick();
      check("t1_end_busy", {31'd0, oBusy}, ZERO);

      // Test 2: simultaneous hit and miss -> miss, gap, idle, hit.
      iHit  = 1'b1;
      iMiss = 1'b1;
      tick();
      iHit  = 1'b0;
      iMiss = 1'b0;
      check("t2_dropped_push", {31'd0, oDropped}, ZERO);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t2_miss_tone", oLeftOut, (i < 8) ? POS : NEG);
         check("t2_dropped", {31'd0, oDropped}, ZERO);
      end
      tick();
      check("t2_gap_left", oLeftOut, ZERO);
      check("t2_gap_busy", {31'd0, oBusy}, ONE);
      tick();
      tick();
      check("t2_gap_busy_last", {31'd0, oBusy}, ONE);
      tick();
      check("t2_idle_busy", {31'd0, oBusy}, ZERO);
      check("t2_idle_left", oLeftOut, ZERO);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t2_hit_tone", oLeftOut, ((i / 4) % 2 == 0) ? POS : NEG);
      end
      tick();
      check("t2_end_left", oLeftOut, ZERO);
      check("t2_end_busy", {31'd0, oBusy}, ZERO);

      // Test 3: three hits while playing with an empty queue.
      iHit = 1'b1;
      tick();
      iHit = 1'b0;
      tick();
      check("t3_play_busy", {31'd0, oBusy}, ONE);
      check("t3_play_left", oLeftOut, POS);
      for (int p = 0; p < 3; p++) begin
         iHit = 1'b1;
         tick();
         iHit = 1'b0;
         check("t3_drop_pulse", {31'd0, oDropped}, (p == 2) ? ONE : ZERO);
         tick();
         check("t3_drop_after", {31'd0, oDropped}, ZERO);
      end
      repeat (80) tick();
      check("t3_drain_busy", {31'd0, oBusy}, ZERO);
      check("t3_drain_left", oLeftOut, ZERO);

      // Test 4: saturation at both rails.
      iHit = 1'b1;
      tick();
      iHit = 1'b0;
      tick();
      iLeftIn  = 32'h7FFF_FFF0;
      iRightIn = 32'd5;
      #1;
      check("t4_sat_hi_left", oLeftOut, PASSTHRU ? 32'h7FFF_FFFF : POS);
      check("t4_hi_right", oRightOut, PASSTHRU ? 32'd105 : POS);
      repeat (4) tick();
      iLeftIn  = 32'h8000_0010;
      iRightIn = 32'hFFFF_FFFB;
      #1;
      check("t4_sat_lo_left", oLeftOut, PASSTHRU ? 32'h8000_0000 : NEG);
      check("t4_lo_right", oRightOut, PASSTHRU ? 32'hFFFF_FF97 : NEG);

      // Test 5: reset mid-tone with one effect queued.
      iHit = 1'b1;
      tick();
      iHit = 1'b0;
      iLeftIn  = 32'h0000_0ABC;
      iRightIn = '0;
      iResetn  = 1'b0;
      #1;
      check("t5_rst_left", oLeftOut, PASSTHRU ? 32'h0000_0ABC : ZERO);
      check("t5_rst_busy", {31'd0, oBusy}, ZERO);
      check("t5_rst_dropped", {31'd0, oDropped}, ZERO);
      tick();
      iResetn = 1'b1;
      repeat (5) tick();
      check("t5_post_busy", {31'd0, oBusy}, ZERO);
      check("t5_post_left", oLeftOut, PASSTHRU ? 32'h0000_0ABC : ZERO);
      check("t5_post_dropped", {31'd0, oDropped}, ZERO);

      // Test 6: audio FIFO handshake strobes.
      iLeftIn = '0;
      iAudioInAvailable = 1'b1;
      iAudioOutAllowed  = 1'b0;
      #1;
      check("t6_a1o0_read", {31'd0, oReadAudioIn}, PASSTHRU ? ZERO : ONE);
      check("t6_a1o0_write", {31'd0, oWriteAudioOut}, ZERO);
      iAudioOutAllowed = 1'b1;
      #1;
      check("t6_a1o1_read", {31'd0, oReadAudioIn}, ONE);
      check("t6_a1o1_write", {31'd0, oWriteAudioOut}, ONE);
      iAudioInAvailable = 1'b0;
      #1;
      check("t6_a0o1_read", {31'd0, oReadAudioIn}, ZERO);
      check("t6_a0o1_write", {31'd0, oWriteAudioOut}, PASSTHRU ? ZERO : ONE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
